// File: rtl/alu_status_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_status_stage_if : valid/ready stream carrying an ALU result and flags.
// Rev 1.0
// ----------------------------------------------------------------------------
interface alu_status_stage_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             flags_we;

  modport master (output valid, result, flags, flags_we, input ready);
  modport slave  (input valid, result, flags, flags_we, output ready);
endinterface
`default_nettype wire

// File: rtl/alu_status_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_status_stage : ALU result/flags FIFO, status commit and jump evaluation.
// Optional macro STATUS_OVF_COUNT_EN builds the saturating overflow counter.
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_status_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  alu_status_stage_if.slave  in_if,
  alu_status_stage_if.master out_if,
  output logic [3:0]         status,
  input  logic [2:0]         cond_sel,
  output logic               jump_taken,
  output logic [7:0]         ovf_count
);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = WIDTH + 5;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  logic [WIDTH-1:0]   head_result;
  logic [3:0]         head_flags;
  logic               head_we;
  logic               z, n, c, v, lt;

  assign {head_result, head_flags, head_we} = mem[rd_ptr];

  assign in_if.ready  = (count < FULL);
  assign out_if.valid = (count != '0);
  assign push         = in_if.valid && in_if.ready;
  assign pop          = out_if.valid && out_if.ready;

  // Masked while empty so stale storage never shows (and reads zero after reset).
  assign out_if.result   = out_if.valid ? head_result : '0;
  assign out_if.flags    = out_if.valid ? head_flags  : 4'h0;
  assign out_if.flags_we = out_if.valid ? head_we     : 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_if.result, in_if.flags, in_if.flags_we};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status <= 4'h0;
    end else if (pop && head_we) begin
      status <= head_flags;
    end
  end

  assign {z, n, c, v} = status;
  assign lt = n ^ v;

  always_comb begin
    jump_taken = 1'b0;
    case (cond_sel)
      3'b000:  jump_taken = 1'b1;
      3'b001:  jump_taken = z;
      3'b010:  jump_taken = !z;
      3'b011:  jump_taken = !z && !lt;
      3'b100:  jump_taken = !lt;
      3'b101:  jump_taken = lt;
      3'b110:  jump_taken = z || lt;
      default: jump_taken = c;
    endcase
  end

`ifdef STATUS_OVF_COUNT_EN
  logic [7:0] ovf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= 8'h00;
    end else if (pop && head_we && head_flags[0] && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  assign ovf_count = ovf_cnt;
`else
  assign ovf_count = 8'h00;
`endif

endmodule
`default_nettype wire
